// File: rtl/round_robin_arbitrado_tester_if.sv
// Bundle of arbiter inputs (schedule table, FIFO status) and the side-by-side
// grant outputs of the two arbiter cores.
interface round_robin_arbitrado_tester_if #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64,
    parameter int BUF_WIDTH      = 3,
    parameter int TABLE_SIZE     = 8
);
    localparam int QW = $clog2(QUEUE_QUANTITY);
    localparam int WW = $clog2(MAX_WEIGHT);

    logic                                enb;
    logic [TABLE_SIZE*WW-1:0]            pesos;
    logic [TABLE_SIZE*QW-1:0]            selecciones;
    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter;
    logic [QW-1:0]                       selector;
    logic                                selector_enb;
    logic [QW-1:0]                       sint_selector;
    logic                                sint_selector_enb;

    modport master (
        output enb, pesos, selecciones, buf_empty, fifo_counter,
        input  selector, selector_enb, sint_selector, sint_selector_enb
    );

    modport slave (
        input  enb, pesos, selecciones, buf_empty, fifo_counter,
        output selector, selector_enb, sint_selector, sint_selector_enb
    );
endinterface

// File: rtl/round_robin_arbitrado_tester.sv
// Two independently coded copies of a table-driven weighted round-robin queue
// arbiter, fed identical inputs so their registered grants can be compared.
module round_robin_arbitrado_tester #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64,
    parameter int BUF_WIDTH      = 3,
    parameter int TABLE_SIZE     = 8
) (
    input logic clk,
    input logic rst,
    round_robin_arbitrado_tester_if.slave bus
);
    localparam int QW = $clog2(QUEUE_QUANTITY);
    localparam int WW = $clog2(MAX_WEIGHT);
    localparam int PW = $clog2(TABLE_SIZE);
    localparam logic [PW-1:0] LAST_P = PW'(TABLE_SIZE - 1);
    localparam logic [PW-1:0] ONE_P  = PW'(1);
    localparam logic [PW-1:0] ZERO_P = PW'(0);
    localparam logic [WW-1:0] ONE_W  = WW'(1);
    localparam logic [WW-1:0] ZERO_W = WW'(0);
    localparam logic [QW-1:0] ZERO_Q = QW'(0);

    logic [PW-1:0] beh_p_r;
    logic [WW-1:0] beh_c_r;
    logic [QW-1:0] beh_q_s;
    logic [WW-1:0] beh_w_s;

    logic [PW-1:0] sint_p_r;
    logic [WW-1:0] sint_c_r;
    logic [QW-1:0] sint_q_s;
    logic [WW-1:0] sint_w_s;
    logic          sint_skip_s;
    logic          sint_last_s;
    logic [PW-1:0] sint_p_inc_s;
    logic [PW-1:0] sint_p_d_s;
    logic [WW-1:0] sint_c_d_s;
    logic [QW-1:0] sint_sel_d_s;
    logic          sint_en_d_s;

    // Behavioural core: live lookup of the current table slot.
    always_comb begin
        beh_q_s = bus.selecciones[beh_p_r*QW +: QW];
        beh_w_s = bus.pesos[beh_p_r*WW +: WW];
    end

    // Behavioural core: slot pointer, grant counter and registered grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beh_p_r          <= ZERO_P;
            beh_c_r          <= ZERO_W;
            bus.selector     <= ZERO_Q;
            bus.selector_enb <= 1'b0;
        end else if (!bus.enb) begin
            bus.selector_enb <= 1'b0;
        end else if ((beh_w_s == ZERO_W) || bus.buf_empty[beh_q_s] || (beh_c_r >= beh_w_s)) begin
            // Ineligible or exhausted slot: one idle cycle, move on.
            bus.selector_enb <= 1'b0;
            beh_p_r          <= (beh_p_r == LAST_P) ? ZERO_P : beh_p_r + ONE_P;
            beh_c_r          <= ZERO_W;
        end else begin
            bus.selector     <= beh_q_s;
            bus.selector_enb <= 1'b1;
            if ((beh_c_r + ONE_W) == beh_w_s) begin
                beh_p_r <= (beh_p_r == LAST_P) ? ZERO_P : beh_p_r + ONE_P;
                beh_c_r <= ZERO_W;
            end else begin
                beh_c_r <= beh_c_r + ONE_W;
            end
        end
    end

    // Structural core: AND-OR slot multiplexer and explicit next-state muxes.
    always_comb begin
        sint_w_s = ZERO_W;
        sint_q_s = ZERO_Q;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            sint_w_s = sint_w_s | (bus.pesos[i*WW +: WW]       & {WW{sint_p_r == PW'(i)}});
            sint_q_s = sint_q_s | (bus.selecciones[i*QW +: QW] & {QW{sint_p_r == PW'(i)}});
        end
        sint_skip_s  = ~(|sint_w_s) | bus.buf_empty[sint_q_s] | ~(sint_c_r < sint_w_s);
        sint_last_s  = ((sint_c_r + ONE_W) == sint_w_s);
        sint_p_inc_s = (sint_p_r == LAST_P) ? ZERO_P : sint_p_r + ONE_P;
        sint_p_d_s   = (bus.enb & (sint_skip_s | sint_last_s)) ? sint_p_inc_s : sint_p_r;
        sint_c_d_s   = ~bus.enb ? sint_c_r :
                       ((sint_skip_s | sint_last_s) ? ZERO_W : sint_c_r + ONE_W);
        sint_en_d_s  = bus.enb & ~sint_skip_s;
        sint_sel_d_s = sint_en_d_s ? sint_q_s : bus.sint_selector;
    end

    // Structural core: state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sint_p_r              <= ZERO_P;
            sint_c_r              <= ZERO_W;
            bus.sint_selector     <= ZERO_Q;
            bus.sint_selector_enb <= 1'b0;
        end else begin
            sint_p_r              <= sint_p_d_s;
            sint_c_r              <= sint_c_d_s;
            bus.sint_selector     <= sint_sel_d_s;
            bus.sint_selector_enb <= sint_en_d_s;
        end
    end
endmodule

// File: tb/tb_round_robin_arbitrado_tester.sv
// Directed bench: a slot/weight model plus hand-written grant sequences, checked
// against both arbiter cores every cycle.
module tb_round_robin_arbitrado_tester;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   chk_on;

    round_robin_arbitrado_tester_if bus ();

    round_robin_arbitrado_tester dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: table slot index, grants issued in this slot, last grant.
    int m_p, m_c, m_sel, m_en;
    int mq, mw;
    assign mq = int'(bus.selecciones[m_p*2 +: 2]);
    assign mw = int'(bus.pesos[m_p*6 +: 6]);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_p <= 0; m_c <= 0; m_sel <= 0; m_en <= 0;
        end else if (!bus.enb) begin
            m_en <= 0;
        end else if (mw == 0 || bus.buf_empty[mq] || m_c >= mw) begin
            m_en <= 0; m_p <= (m_p + 1) % 8; m_c <= 0;
        end else begin
            m_sel <= mq; m_en <= 1;
            if (m_c + 1 == mw) begin
                m_p <= (m_p + 1) % 8; m_c <= 0;
            end else begin
                m_c <= m_c + 1;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both cores against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("beh_sel",  int'(bus.selector),          m_sel);
            check("beh_enb",  int'(bus.selector_enb),      m_en);
            check("sint_sel", int'(bus.sint_selector),     m_sel);
            check("sint_enb", int'(bus.sint_selector_enb), m_en);
        end
    end

    function automatic int code_beh();
        return int'({bus.selector_enb, bus.selector});
    endfunction

    function automatic int code_sint();
        return int'({bus.sint_selector_enb, bus.sint_selector});
    endfunction

    // Expect n consecutive cycles showing {enb,selector} == code on both cores.
    task automatic run_expect(input string nm, input int n, input int code);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check(nm, code_beh(), code);
            check({nm, "_sint"}, code_sint(), code);
        end
    endtask

    task automatic set_table(input int w[8], input int s[8]);
        for (int i = 0; i < 8; i++) begin
            bus.pesos[i*6 +: 6]       = 6'(w[i]);
            bus.selecciones[i*2 +: 2] = 2'(s[i]);
        end
    endtask

    int t3_codes[8] = '{5, 6, 4, 5, 6, 6, 6, 7};

    initial begin
        checks = 0; errors = 0; chk_on = 1'b0;
        rst = 1'b1;
        bus.enb = 1'b0;
        bus.pesos = '0;
        bus.selecciones = '0;
        bus.buf_empty = 4'b1111;
        bus.fifo_counter = 12'h5a3;
        #1 rst = 1'b0;

        // T1: reset held for 4 cycles
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_on = 1'b1;
            check("t1_reset", code_beh(), 0);
            check("t1_reset_sint", code_sint(), 0);
        end
        set_table('{6, 5, 7, 3, 1, 2, 3, 6}, '{3, 1, 2, 0, 1, 2, 0, 2});
        bus.buf_empty = 4'b0000;
        bus.enb = 1'b1;
        rst = 1'b1;

        // T2: one full 33-cycle period by hand, a second one via the model
        run_expect("t2_e0", 6, 7);
        run_expect("t2_e1", 5, 5);
        run_expect("t2_e2", 7, 6);
        run_expect("t2_e3", 3, 4);
        run_expect("t2_e4", 1, 5);
        run_expect("t2_e5", 2, 6);
        run_expect("t2_e6", 3, 4);
        run_expect("t2_e7", 6, 6);
        repeat (33) @(negedge clk);

        // T3: reprogram after two grants of e0 (c=2 >= new weight 1)
        run_expect("t3_pre", 2, 7);
        set_table('{1, 1, 1, 1, 1, 1, 1, 1}, '{3, 1, 2, 0, 1, 2, 2, 2});
        run_expect("t3_idle", 1, 3);
        for (int k = 0; k < 8; k++) run_expect("t3_seq", 1, t3_codes[k]);
        repeat (16) @(negedge clk);

        // T4: queue 2 empty and e4 weight 0, from a fresh reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_table('{6, 5, 7, 3, 0, 2, 3, 6}, '{3, 1, 2, 0, 1, 2, 0, 2});
        bus.buf_empty = 4'b0100;
        run_expect("t4_e0", 6, 7);
        run_expect("t4_e1", 5, 5);
        run_expect("t4_e2_skip", 1, 1);
        run_expect("t4_e3", 3, 4);
        run_expect("t4_e4_skip", 1, 0);
        run_expect("t4_e5_skip", 1, 0);
        run_expect("t4_e6", 3, 4);
        run_expect("t4_e7_skip", 1, 0);

        // T5: enable dropped for 3 cycles mid-slot
        run_expect("t5_pre", 2, 7);
        bus.enb = 1'b0;
        run_expect("t5_hold", 3, 3);
        bus.enb = 1'b1;
        run_expect("t5_rest", 4, 7);
        run_expect("t5_next", 1, 5);

        // T6: asynchronous reset between edges, mid-slot
        rst = 1'b0;
        #1;
        check("t6_async", code_beh(), 0);
        check("t6_async_sint", code_sint(), 0);
        @(negedge clk);
        rst = 1'b1;
        run_expect("t6_restart", 6, 7);
        run_expect("t6_e1", 1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
